except_ctrl: RTL

Commit-point exception and interrupt scheduler for the single-issue pipeline. It prioritises the exception flags of the instruction at the commit stage and pending interrupts, then drives the CP0 exception interface with a one-cycle update pulse. It then sequences pipeline flush and stall, and hands the redirect PC (exception vector or EPC) to fetch over a valid/ready handshake.

---
 rtl/except_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - commit-point exception/interrupt scheduler with flush and redirect sequencing
//
// Purpose: picks the highest-priority exception or interrupt of the committing
// instruction. It then pulses the CP0 exception fields for one cycle, holds
// flush and stall, and offers the redirect PC to fetch over valid/ready.
//
// Parameters:
//   EXC_VECTOR   redirect target for every exception and interrupt
//   FLUSH_CYCLES cycles flush_o stays high, counted from ENTER (1..15)
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   commit_*                  committing instruction: valid, pc, delay-slot flag
//   exc_*_i, eret_i           exception flags of the committing instruction
//   mem_vaddr_i               data address for load/store address errors
//   status_i, cause_i, epc_i  CP0 state
//   excepttype_o, pc_o, bad_vaddr_o, is_in_delayslot_o
//                             CP0 update fields, non-zero only in ENTER
//   flush_o, stall_req_o      pipeline control
//   redirect_valid_o, redirect_pc_o, redirect_ready_i
//                             redirect handshake to fetch
//
// Optional feature macro: EXC_STATS_EN adds exc_cnt_o / int_cnt_o event counters.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic        commit_ds_i,
    input  logic        exc_adel_if_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_trap_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_adel_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic [31:0] mem_vaddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic        stall_req_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
`ifdef EXC_STATS_EN
    output logic [31:0] exc_cnt_o,
    output logic [31:0] int_cnt_o,
`endif
    input  logic        redirect_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_FLUSH, S_REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] code_q, code_d;
    logic [31:0] epc_lat_q, epc_lat_d;
    logic [31:0] badv_q, badv_d;
    logic        ds_q, ds_d;
    logic [31:0] target_q, target_d;

    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] bad_vaddr_q, bad_vaddr_d;
    logic        ds_out_q, ds_out_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pend;
    logic        any_flag;
    logic        event_hit;
    logic [31:0] sel_code;
    logic [31:0] sel_badv;

    // Status/Cause bits outside IE, EXL and the IM/IP fields play no part here.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    always_comb begin
        int_pend  = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));
        any_flag  = exc_adel_if_i | exc_ri_i | exc_ov_i | exc_trap_i | exc_sys_i |
                    exc_bp_i | exc_adel_i | exc_ades_i | eret_i;
        event_hit = commit_valid_i & (int_pend | any_flag);

        sel_code = 32'h0;
        sel_badv = 32'h0;
        if (int_pend)           sel_code = 32'h1;
        else if (exc_adel_if_i) begin sel_code = 32'h4; sel_badv = commit_pc_i; end
        else if (exc_ri_i)      sel_code = 32'hA;
        else if (exc_ov_i)      sel_code = 32'hC;
        else if (exc_trap_i)    sel_code = 32'hD;
        else if (exc_sys_i)     sel_code = 32'h8;
        else if (exc_bp_i)      sel_code = 32'h9;
        else if (exc_adel_i)    begin sel_code = 32'h4; sel_badv = mem_vaddr_i; end
        else if (exc_ades_i)    begin sel_code = 32'h5; sel_badv = mem_vaddr_i; end
        else if (eret_i)        sel_code = 32'hE;

        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        epc_lat_d = epc_lat_q;
        badv_d    = badv_q;
        ds_d      = ds_q;
        target_d  = target_q;

        case (state_q)
            S_IDLE: begin
                if (event_hit) begin
                    code_d    = sel_code;
                    epc_lat_d = commit_pc_i;
                    ds_d      = commit_ds_i;
                    badv_d    = sel_badv;
                    // ERET only wins when nothing else is flagged, so code E alone selects EPC.
                    target_d  = (sel_code == 32'hE) ? epc_i : EXC_VECTOR;
                    state_d   = S_ENTER;
                end
            end
            S_ENTER: begin
                cnt_d   = 4'(FLUSH_CYCLES - 1);
                state_d = (FLUSH_CYCLES == 1) ? S_REDIRECT : S_FLUSH;
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                // Leaving when the decremented count reaches zero keeps ENTER plus
                // the FLUSH cycles equal to FLUSH_CYCLES in total.
                if (cnt_q <= 4'd1) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        excepttype_d = 32'h0;
        pc_out_d     = 32'h0;
        bad_vaddr_d  = 32'h0;
        ds_out_d     = 1'b0;
        flush_d      = 1'b0;
        stall_d      = 1'b0;
        rvalid_d     = 1'b0;
        rpc_d        = 32'h0;
        case (state_d)
            S_ENTER: begin
                excepttype_d = code_d;
                pc_out_d     = epc_lat_d;
                bad_vaddr_d  = badv_d;
                ds_out_d     = ds_d;
                flush_d      = 1'b1;
                stall_d      = 1'b1;
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                stall_d = 1'b1;
            end
            S_REDIRECT: begin
                rvalid_d = 1'b1;
                rpc_d    = target_d;
                stall_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            code_q       <= 32'h0;
            epc_lat_q    <= 32'h0;
            badv_q       <= 32'h0;
            ds_q         <= 1'b0;
            target_q     <= 32'h0;
            excepttype_q <= 32'h0;
            pc_out_q     <= 32'h0;
            bad_vaddr_q  <= 32'h0;
            ds_out_q     <= 1'b0;
            flush_q      <= 1'b0;
            stall_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rpc_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            epc_lat_q    <= epc_lat_d;
            badv_q       <= badv_d;
            ds_q         <= ds_d;
            target_q     <= target_d;
            excepttype_q <= excepttype_d;
            pc_out_q     <= pc_out_d;
            bad_vaddr_q  <= bad_vaddr_d;
            ds_out_q     <= ds_out_d;
            flush_q      <= flush_d;
            stall_q      <= stall_d;
            rvalid_q     <= rvalid_d;
            rpc_q        <= rpc_d;
        end
    end

    assign excepttype_o      = excepttype_q;
    assign pc_o              = pc_out_q;
    assign bad_vaddr_o       = bad_vaddr_q;
    assign is_in_delayslot_o = ds_out_q;
    assign flush_o           = flush_q;
    assign stall_req_o       = stall_q;
    assign redirect_valid_o  = rvalid_q;
    assign redirect_pc_o     = rpc_q;

`ifdef EXC_STATS_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] int_cnt_q, int_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        if (state_d == S_ENTER) begin
            if (code_d == 32'h1)       int_cnt_d = int_cnt_q + 32'd1;
            else if (code_d != 32'hE)  exc_cnt_d = exc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt_q <= 32'h0;
            int_cnt_q <= 32'h0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
        end
    end

    assign exc_cnt_o = exc_cnt_q;
    assign int_cnt_o = int_cnt_q;
`endif

endmodule
